result_collector: RTL

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/othello_pkg.sv | 16 +
 rtl/result_fifo.sv | 55 +++++
 rtl/result_collector.sv | 79 +++++++
 3 files changed

// File: rtl/othello_pkg.sv
// Shared widths and the solved-result record that flows from the solver
// pipeline into the result collector.
package othello_pkg;

   localparam int BOARD_W = 64;
   localparam int SCORE_W = 8;
   localparam int SLOT_W  = 5;

   typedef struct packed {
      logic [BOARD_W-1:0]        player;
      logic [BOARD_W-1:0]        opponent;
      logic signed [SCORE_W-1:0] res;
      logic [SLOT_W-1:0]         slot;
   } result_t;

endpackage

// File: rtl/result_fifo.sv
// Show-ahead FIFO: the head entry is visible combinationally from storage.
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module result_fifo
   import othello_pkg::*;
#(
   parameter int  DEPTH = 16,
   parameter type T     = result_t
) (
   input  logic                     iCLOCK,
   input  logic                     inRESET,
   input  logic                     push,
   input  T                         din,
   input  logic                     pop,
   output T                         dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   T                  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // The caller gates push/pop; this block never checks full or empty.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign valid = (count != '0);

   // Empty reads are forced to zero so unwritten storage never leaks out.
   always_comb begin
      dout = '0;
      if (valid) dout = mem[rd_ptr];
   end

endmodule

// File: rtl/result_collector.sv
// Collects solver results into a FIFO, counting solved and dropped events.
// oValid/iReady: an entry transfers on every edge with both high; while oValid=1 and iReady=0 the head holds.
module result_collector
   import othello_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 32,
   parameter int DROP_W = 16
) (
   input  logic                      iCLOCK,
   input  logic                      inRESET,
   input  logic                      iSolved,
   input  logic [BOARD_W-1:0]        iPlayer,
   input  logic [BOARD_W-1:0]        iOpponent,
   input  logic signed [SCORE_W-1:0] iRes,
   input  logic [SLOT_W-1:0]         iSlot,
   output logic                      oValid,
   input  logic                      iReady,
   output logic [BOARD_W-1:0]        oPlayer,
   output logic [BOARD_W-1:0]        oOpponent,
   output logic signed [SCORE_W-1:0] oRes,
   output logic [SLOT_W-1:0]         oSlot,
   output logic [$clog2(DEPTH):0]    oCount,
   output logic                      oOverflow,
   input  logic                      iClearOverflow,
   output logic [CNT_W-1:0]          oSolvedTotal,
   output logic [DROP_W-1:0]         oDropTotal
);

   localparam int OCC_W = $clog2(DEPTH) + 1;

   result_t din;
   result_t head;
   logic    full;
   logic    pop;
   logic    push;
   logic    drop;

   assign din  = '{player: iPlayer, opponent: iOpponent, res: iRes, slot: iSlot};
   assign full = (oCount == OCC_W'(DEPTH));
   assign pop  = oValid & iReady;
   // A pop on the same edge frees the slot a full FIFO needs for the push.
   assign push = iSolved & (~full | pop);
   assign drop = iSolved & full & ~pop;

   result_fifo #(
      .DEPTH (DEPTH),
      .T     (result_t)
   ) u_fifo (
      .iCLOCK  (iCLOCK),
      .inRESET (inRESET),
      .push    (push),
      .din     (din),
      .pop     (pop),
      .dout    (head),
      .valid   (oValid),
      .count   (oCount)
   );

   assign oPlayer   = head.player;
   assign oOpponent = head.opponent;
   assign oRes      = head.res;
   assign oSlot     = head.slot;

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         oSolvedTotal <= '0;
         oDropTotal   <= '0;
         oOverflow    <= 1'b0;
      end else begin
         if (iSolved && (oSolvedTotal != '1)) oSolvedTotal <= oSolvedTotal + CNT_W'(1);
         if (drop && (oDropTotal != '1))      oDropTotal   <= oDropTotal + DROP_W'(1);
         // A drop on the clearing edge wins so no overflow goes unreported.
         if (drop)                oOverflow <= 1'b1;
         else if (iClearOverflow) oOverflow <= 1'b0;
      end
   end

endmodule
